shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
Parametrised, pipelined barrel shifter that supersedes the fixed 32-bit, 0..3-position LSL mux array in the ALU datapath. It performs LSL, LSR, ASR or ROR by any amount 0..WIDTH-1. The log2(WIDTH) mux layers are split across STAGES register stages. A valid/ready handshake lets the block sit between the operand-fetch and writeback stages and stall with them.

Parameters:
WIDTH, 32, data width in bits; power of two, 4..64.
SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.
STAGES, 2, number of pipeline register stages, 1..SHW.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  input operand valid.
in_ready  output  1  block can accept an operand this cycle.
d_in  input  WIDTH  operand.
shamt  input  SHW  shift amount, 0..WIDTH-1.
op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
out_valid  output  1  d_out holds a valid result.
out_ready  input  1  downstream accepts the result.
d_out  output  WIDTH  shifted result.

Behaviour:
- Reset: when reset=1 at a clock edge, all stage valid bits go to 0 and all data/op/shamt registers go to 0, so out_valid=0 and d_out=0. Any in-flight operations are discarded. in_ready=1 during and after reset.
- Layer split: layer j (j=0..SHW-1) shifts by 2^j when shamt[j]=1. Stage k evaluates layers k*L .. min((k+1)*L, SHW)-1, where L=ceil(SHW/STAGES), then registers the partial result, op, the remaining shamt bits and a valid bit.
- Advance rule: adv = ~out_valid | out_ready. All stages move together when adv=1 and hold their contents when adv=0. in_ready = adv (combinational).
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no backpressure. Throughput is one operation per cycle.
- Bubbles: if in_valid=0 while adv=1, a bubble (valid=0) enters stage 0. Bubbles are not compressed.
- Stall: d_out and out_valid stay stable while out_valid=1 and out_ready=0.
- Fill bits: LSL fills with zeros; LSR fills with zeros; ASR fills with d_in[WIDTH-1]; ROR wraps bits modulo WIDTH.
- shamt=0: d_out = d_in for every op.
- shamt=WIDTH-1 is legal: LSL leaves only bit 0 moved to the MSB; ASR yields all copies of the sign bit.
- Simultaneous events: an input and an output transfer in the same cycle are legal and required for full throughput.
- Reset priority: reset asserted together with in_valid drops the input.

Optional Feature:
Macro SHIFT_PIPE_CARRY_EN.
- Defined: adds output port carry_out (1 bit), pipelined alongside d_out and valid together with out_valid. Its value is the last bit shifted out:
  - LSL: d_in[WIDTH-shamt]
  - LSR/ASR: d_in[shamt-1]
  - ROR: d_out[WIDTH-1]
  - shamt=0: 0
  - reset value: 0
- Not defined: the port is absent and no carry logic or registers exist.

Test Plan:
1. WIDTH=32, STAGES=2: LSL, d_in=0x0000_00F1, shamt=4 -> out_valid rises 2 cycles later, d_out=0x0000_0F10.
2. ASR, d_in=0x8000_0000, shamt=31 -> d_out=0xFFFF_FFFF. LSR with the same operands -> 0x0000_0001.
3. ROR, d_in=0x0000_0001, shamt=1 -> 0x8000_0000. ROR with shamt=0 -> 0x0000_0001. With SHIFT_PIPE_CARRY_EN, carry_out=1 for the first case and 0 for the second.
4. Back-to-back input of 4 ops with out_ready=1 -> 4 results on consecutive cycles, in order. Then hold out_ready=0 for 3 cycles -> in_ready=0, d_out stable for those cycles, and the stream resumes with no loss or duplication.
5. Assert reset while 2 ops are in flight -> out_valid=0 and d_out=0 the next cycle, in_ready=1, and no stale result ever appears.
6. Sweep all op values and shamt 0..WIDTH-1 with random d_in at WIDTH=8 STAGES=1 and WIDTH=64 STAGES=6 -> every result matches the reference model, latency equals STAGES.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined LSL/LSR/ASR/ROR barrel shifter with a valid/ready handshake.
// Define SHIFT_PIPE_CARRY_EN to add carry_out, the last bit shifted out, aligned with d_out.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int STAGES = 2,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out
`ifdef SHIFT_PIPE_CARRY_EN
    ,
    output logic             carry_out
`endif
);
    localparam int L = (SHW + STAGES - 1) / STAGES;

    logic              adv;
    logic [WIDTH-1:0]  dat_d [0:STAGES-1];
    logic [WIDTH-1:0]  dat_q [0:STAGES-1];
    logic [1:0]        op_i  [0:STAGES-1];
    logic [1:0]        op_q  [0:STAGES-1];
    logic [SHW-1:0]    sh_i  [0:STAGES-1];
    logic [SHW-1:0]    sh_q  [0:STAGES-1];
    logic [STAGES-1:0] vld_i;
    logic [STAGES-1:0] vld_q;
`ifdef SHIFT_PIPE_CARRY_EN
    logic [STAGES-1:0] car_d;
    logic [STAGES-1:0] car_q;
    assign carry_out = car_q[STAGES-1];
`endif

    assign adv       = ~vld_q[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign d_out     = dat_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * L;
        localparam int HI = (k + 1) * L < SHW ? (k + 1) * L : SHW;
        localparam int N  = HI > LO ? HI - LO : 0;
        logic [WIDTH-1:0] x [0:N];
`ifdef SHIFT_PIPE_CARRY_EN
        logic [N:0] c;
`endif
        if (k == 0) begin : g_in
            assign x[0]     = d_in;
            assign op_i[k]  = op;
            assign sh_i[k]  = shamt;
            assign vld_i[k] = in_valid;
`ifdef SHIFT_PIPE_CARRY_EN
            assign c[0]     = 1'b0;
`endif
        end else begin : g_in
            assign x[0]     = dat_q[k-1];
            assign op_i[k]  = op_q[k-1];
            assign sh_i[k]  = sh_q[k-1];
            assign vld_i[k] = vld_q[k-1];
`ifdef SHIFT_PIPE_CARRY_EN
            assign c[0]     = car_q[k-1];
`endif
        end
        for (genvar i = 0; i < N; i++) begin : g_layer
            localparam int S = 1 << (LO + i);
            logic [WIDTH-1:0] r;
            assign r = op_i[k] == 2'd0 ? x[i] << S :
                       op_i[k] == 2'd1 ? x[i] >> S :
                       op_i[k] == 2'd2 ? ({WIDTH{x[i][WIDTH-1]}} << (WIDTH - S)) | (x[i] >> S) :
                                         (x[i] >> S) | (x[i] << (WIDTH - S));
            assign x[i+1] = sh_i[k][LO+i] ? r : x[i];
`ifdef SHIFT_PIPE_CARRY_EN
            assign c[i+1] = sh_i[k][LO+i] ? (op_i[k] == 2'd0 ? x[i][WIDTH-S] :
                                             op_i[k] == 2'd3 ? r[WIDTH-1] : x[i][S-1]) : c[i];
`endif
        end
        assign dat_d[k] = x[N];
`ifdef SHIFT_PIPE_CARRY_EN
        assign car_d[k] = c[N];
`endif
    end

    // all stages advance together; reset wipes contents so no stale result survives
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
`ifdef SHIFT_PIPE_CARRY_EN
            car_q <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
                op_q[k]  <= '0;
                sh_q[k]  <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_i;
`ifdef SHIFT_PIPE_CARRY_EN
            car_q <= car_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= dat_d[k];
                op_q[k]  <= op_i[k];
                sh_q[k]  <= sh_i[k];
            end
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe at three width/stage configurations.
module tb_shift_pipe;
    typedef struct {
        logic [63:0] d;
        logic        c;
        int          t;
        int          s;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int W  = c == 0 ? 32 : c == 1 ? 8 : 64;
        localparam int ST = c == 0 ? 2 : c == 1 ? 1 : 6;
        localparam int SW = $clog2(W);

        logic          reset = 1'b1;
        logic          in_valid = 1'b0;
        logic          in_ready;
        logic [W-1:0]  d_in = '0;
        logic [SW-1:0] shamt = '0;
        logic [1:0]    op = '0;
        logic          out_valid;
        logic          out_ready = 1'b1;
        logic [W-1:0]  d_out;
`ifdef SHIFT_PIPE_CARRY_EN
        logic          carry_out;
`endif
        exp_t q[$];
        int   stalls = 0;
        bit   seen = 0;
        bit   rst_prev = 0;

        shift_pipe #(.WIDTH(W), .STAGES(ST)) u_dut (
            .clk(clk),
            .reset(reset),
            .in_valid(in_valid),
            .in_ready(in_ready),
            .d_in(d_in),
            .shamt(shamt),
            .op(op),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .d_out(d_out)
`ifdef SHIFT_PIPE_CARRY_EN
            ,
            .carry_out(carry_out)
`endif
        );

        // reference: each output bit picks its source bit from the shift rules
        function automatic exp_t model(logic [W-1:0] d, int s, logic [1:0] o);
            exp_t e;
            e.d = '0;
            for (int i = 0; i < W; i++)
                e.d[i] = o == 2'd0 ? (i >= s ? d[i-s] : 1'b0) :
                         o == 2'd3 ? d[(i+s)%W] :
                         i + s < W ? d[i+s] : (o == 2'd2 ? d[W-1] : 1'b0);
            e.c = s == 0 ? 1'b0 : o == 2'd0 ? d[W-s] : o == 2'd3 ? e.d[W-1] : d[s-1];
            e.t = cyc;
            e.s = stalls;
            return e;
        endfunction

        task automatic cycle(bit rst, bit v, logic [W-1:0] d, int s, logic [1:0] o, bit rdy, output bit acc);
            @(negedge clk);
            reset = rst;
            in_valid = v;
            d_in = d;
            shamt = SW'(s);
            op = o;
            out_ready = rdy;
            #1;
            acc = !rst && v && in_ready;
            if (rst) begin
                q.delete();
                seen = 0;
            end else if (acc) q.push_back(model(d, s, o));
        endtask

        task automatic send(logic [W-1:0] d, int s, logic [1:0] o, bit rnd);
            bit acc = 0;
            for (int n = 0; n < 50 && !acc; n++)
                cycle(1'b0, 1'b1, d, s, o, rnd ? ($urandom_range(3) != 0) : 1'b1, acc);
            if (!acc) chk($sformatf("c%0d accept_timeout", c), in_ready, 1);
        endtask

        task automatic idle(bit rdy);
            bit acc;
            cycle(1'b0, 1'b0, '0, 0, 2'd0, rdy, acc);
        endtask

        initial begin
            bit acc;
            logic [63:0] r;
            repeat (3) cycle(1'b1, 1'b0, '0, 0, 2'd0, 1'b1, acc);
            send(W'(64'hF1), 4, 2'd0, 0);
            repeat (ST + 1) idle(1);
            send(W'(1) << (W - 1), W - 1, 2'd2, 0);
            send(W'(1) << (W - 1), W - 1, 2'd1, 0);
            send(W'(1), 1, 2'd3, 0);
            send(W'(1), 0, 2'd3, 0);
            repeat (ST + 1) idle(1);
            for (int i = 0; i < 4; i++) send(W'(64'h1234_5678_9ABC_DEF0 >> (8 * i)), i + 1, 2'(i), 0);
            repeat (3) cycle(1'b0, 1'b1, W'(64'hA5A5_5A5A_C3C3_3C3C), 3, 2'd2, 1'b0, acc);
            send(W'(64'hA5A5_5A5A_C3C3_3C3C), 3, 2'd2, 0);
            repeat (ST + 2) idle(1);
            send(W'(64'h0F0F_0F0F_0F0F_0F0F), 1, 2'd0, 0);
            send(W'(64'hF0F0_F0F0_F0F0_F0F0), 2, 2'd1, 0);
            cycle(1'b1, 1'b1, W'(64'hDEAD_BEEF_DEAD_BEEF), 5, 2'd0, 1'b1, acc);
            repeat (ST + 2) idle(1);
            for (int o = 0; o < 4; o++)
                for (int s = 0; s < W; s++) begin
                    r = {$urandom, $urandom};
                    if ($urandom_range(3) == 0) idle(1'($urandom_range(1)));
                    send(r[W-1:0], s, 2'(o), 1);
                end
            for (int n = 0; n < 200 && q.size() != 0; n++) idle(1);
            chk($sformatf("c%0d drain", c), 64'(q.size()), 0);
            idle(1);
            chk($sformatf("c%0d idle_valid", c), out_valid, 0);
            done_cnt++;
        end

        // monitor: compare whatever the DUT presents against the scoreboard head
        always @(negedge clk) begin
            #2;
            if (rst_prev) begin
                chk($sformatf("c%0d reset_valid", c), out_valid, 0);
                chk($sformatf("c%0d reset_dout", c), d_out, 0);
                chk($sformatf("c%0d reset_ready", c), in_ready, 1);
`ifdef SHIFT_PIPE_CARRY_EN
                chk($sformatf("c%0d reset_carry", c), carry_out, 0);
`endif
            end
            if (!reset) begin
                chk($sformatf("c%0d in_ready", c), in_ready, !out_valid || out_ready);
                if (out_valid && q.size() == 0) chk($sformatf("c%0d stale_valid", c), out_valid, 0);
                else if (out_valid) begin
                    chk($sformatf("c%0d dout", c), d_out, q[0].d);
`ifdef SHIFT_PIPE_CARRY_EN
                    chk($sformatf("c%0d carry", c), carry_out, q[0].c);
`endif
                    if (!seen) chk($sformatf("c%0d latency", c), 64'(cyc - q[0].t), 64'(ST + stalls - q[0].s));
                    seen = 1;
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
                if (out_valid && !out_ready) stalls++;
            end
            rst_prev = reset;
        end
    end

    initial begin
        fork
            wait (done_cnt == 3);
            begin
                #200000;
                chk("global_timeout", 64'(done_cnt), 3);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
